// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: decodes opcode/funct and
// steps fetch/decode/execute/memory/writeback, driving every select and strobe.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       illegal,
  output logic [3:0] state
);

  // State codes follow the order FETCH=0 .. JAL=13.
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB,
    I_EXEC, I_WB, BRANCH, JUMP, JR, JAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A, FN_JR = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR = 3'd3, ALU_XOR = 3'd4, ALU_SLT = 3'd5;

  state_t cur, nxt;
  // lw/sw choice is captured in DECODE so MEM_ADDR never looks at opcode.
  logic   is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= FETCH;
      is_store <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    nxt        = cur;
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = R_EXEC;
              FN_JR:                                 nxt = JR;
              default: begin
                nxt     = FETCH;
                illegal = 1'b1;
              end
            endcase
          end
          OP_LW, OP_SW:     nxt = MEM_ADDR;
          OP_ADDI, OP_XORI: nxt = I_EXEC;
          OP_BEQ, OP_BNE:   nxt = BRANCH;
          OP_J:             nxt = JUMP;
          OP_JAL:           nxt = JAL;
          default: begin
            nxt     = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt       = is_store ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
        nxt = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        nxt       = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        nxt       = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        nxt       = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'd1;
        pc_en     = (opcode == OP_BNE) ? !zero : zero;
        nxt       = FETCH;
      end
      JUMP: begin
        pc_src = 2'd3;
        pc_en  = 1'b1;
        nxt    = FETCH;
      end
      JR: begin
        pc_src = 2'd2;
        pc_en  = 1'b1;
        nxt    = FETCH;
      end
      JAL: begin
        pc_src     = 2'd3;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        nxt        = FETCH;
      end
      default: nxt = FETCH;
    endcase
    // Strobes are forced low the instant reset asserts, even mid-access.
    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares state plus the full control word.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3;
  localparam int S_MEM_WB = 4, S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7;
  localparam int S_I_EXEC = 8, S_I_WB = 9, S_BRANCH = 10, S_JUMP = 11;
  localparam int S_JR = 12, S_JAL = 13;

  logic [18:0] ctl;
  assign ctl = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [18:0] pk(input int pe, ps, iod, mr, mw, irw, rw,
                                     rd, m2r, asa, asb, ac, il);
    return {pe[0], ps[1:0], iod[0], mr[0], mw[0], irw[0], rw[0], rd[1:0],
            m2r[1:0], asa[0], asb[1:0], ac[2:0], il[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk(input string tag, input int st, input logic [18:0] v);
    #1;
    check({tag, ".state"}, {28'd0, state}, st);
    check({tag, ".ctl"}, {13'd0, ctl}, {13'd0, v});
  endtask

  task automatic cyc(input string tag, input int st, input logic [18:0] v);
    chk(tag, st, v);
    @(negedge clk);
  endtask

  // Hand-derived control words, fields in the order of ctl above.
  logic [18:0] v_rst, v_fetch, v_fwait, v_dec, v_ill, v_maddr, v_mrd, v_mwb;
  logic [18:0] v_mwr, v_radd, v_rsub, v_rand, v_ror, v_rslt, v_rwb, v_ixor;
  logic [18:0] v_iwb, v_br_t, v_br_n, v_j, v_jr, v_jal;

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [18:0] vex);
    opcode = 6'h00; funct = fn; mem_ready = 1'b1;
    cyc({tag, ".fetch"}, S_FETCH, v_fetch);
    cyc({tag, ".dec"}, S_DECODE, v_dec);
    cyc({tag, ".exec"}, S_R_EXEC, vex);
    cyc({tag, ".wb"}, S_R_WB, v_rwb);
  endtask

  task automatic run_br(input string tag, input logic [5:0] op, input logic z,
                        input logic [18:0] vbr);
    opcode = op; funct = 6'h00; zero = z; mem_ready = 1'b1;
    cyc({tag, ".fetch"}, S_FETCH, v_fetch);
    cyc({tag, ".dec"}, S_DECODE, v_dec);
    cyc({tag, ".br"}, S_BRANCH, vbr);
  endtask

  task automatic run_jump(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input int st, input logic [18:0] vj);
    opcode = op; funct = fn; mem_ready = 1'b1;
    cyc({tag, ".fetch"}, S_FETCH, v_fetch);
    cyc({tag, ".dec"}, S_DECODE, v_dec);
    cyc({tag, ".exec"}, st, vj);
  endtask

  initial begin
    v_rst   = pk(0,0,0,0,0,0,0,0,0,0,1,0,0);
    v_fetch = pk(1,0,0,1,0,1,0,0,0,0,1,0,0);
    v_fwait = pk(0,0,0,1,0,0,0,0,0,0,1,0,0);
    v_dec   = pk(0,0,0,0,0,0,0,0,0,0,3,0,0);
    v_ill   = pk(0,0,0,0,0,0,0,0,0,0,3,0,1);
    v_maddr = pk(0,0,0,0,0,0,0,0,0,1,2,0,0);
    v_mrd   = pk(0,0,1,1,0,0,0,0,0,0,0,0,0);
    v_mwb   = pk(0,0,0,0,0,0,1,0,1,0,0,0,0);
    v_mwr   = pk(0,0,1,0,1,0,0,0,0,0,0,0,0);
    v_radd  = pk(0,0,0,0,0,0,0,0,0,1,0,0,0);
    v_rsub  = pk(0,0,0,0,0,0,0,0,0,1,0,1,0);
    v_rand  = pk(0,0,0,0,0,0,0,0,0,1,0,2,0);
    v_ror   = pk(0,0,0,0,0,0,0,0,0,1,0,3,0);
    v_rslt  = pk(0,0,0,0,0,0,0,0,0,1,0,5,0);
    v_rwb   = pk(0,0,0,0,0,0,1,1,0,0,0,0,0);
    v_ixor  = pk(0,0,0,0,0,0,0,0,0,1,2,4,0);
    v_iwb   = pk(0,0,0,0,0,0,1,0,0,0,0,0,0);
    v_br_t  = pk(1,1,0,0,0,0,0,0,0,1,0,1,0);
    v_br_n  = pk(0,1,0,0,0,0,0,0,0,1,0,1,0);
    v_j     = pk(1,3,0,0,0,0,0,0,0,0,0,0,0);
    v_jr    = pk(1,2,0,0,0,0,0,0,0,0,0,0,0);
    v_jal   = pk(1,3,0,0,0,0,1,2,2,0,0,0,0);

    // Reset with mem_ready high: FETCH selects, all strobes low.
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    cyc("reset", S_FETCH, v_rst);
    rst_n = 1'b1;

    run_r("add", 6'h20, v_radd);
    run_r("sub", 6'h22, v_rsub);
    run_r("and", 6'h24, v_rand);
    run_r("or", 6'h25, v_ror);
    run_r("slt", 6'h2A, v_rslt);

    // lw with two wait cycles in MEM_RD; mem_ready low in DECODE/MEM_ADDR is ignored.
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    cyc("lw.fetch", S_FETCH, v_fetch);
    mem_ready = 1'b0;
    cyc("lw.dec", S_DECODE, v_dec);
    cyc("lw.addr", S_MEM_ADDR, v_maddr);
    cyc("lw.rd0", S_MEM_RD, v_mrd);
    cyc("lw.rd1", S_MEM_RD, v_mrd);
    mem_ready = 1'b1;
    cyc("lw.rd2", S_MEM_RD, v_mrd);
    cyc("lw.wb", S_MEM_WB, v_mwb);

    // sw with one wait cycle in FETCH.
    opcode = 6'h2B; mem_ready = 1'b0;
    cyc("sw.fwait", S_FETCH, v_fwait);
    mem_ready = 1'b1;
    cyc("sw.fetch", S_FETCH, v_fetch);
    cyc("sw.dec", S_DECODE, v_dec);
    cyc("sw.addr", S_MEM_ADDR, v_maddr);
    cyc("sw.wr", S_MEM_WR, v_mwr);

    opcode = 6'h08; funct = 6'h00;
    cyc("addi.fetch", S_FETCH, v_fetch);
    cyc("addi.dec", S_DECODE, v_dec);
    cyc("addi.exec", S_I_EXEC, v_maddr);
    cyc("addi.wb", S_I_WB, v_iwb);
    opcode = 6'h0E;
    cyc("xori.fetch", S_FETCH, v_fetch);
    cyc("xori.dec", S_DECODE, v_dec);
    cyc("xori.exec", S_I_EXEC, v_ixor);
    cyc("xori.wb", S_I_WB, v_iwb);

    run_br("beq_z1", 6'h04, 1'b1, v_br_t);
    run_br("beq_z0", 6'h04, 1'b0, v_br_n);
    run_br("bne_z1", 6'h05, 1'b1, v_br_n);
    run_br("bne_z0", 6'h05, 1'b0, v_br_t);

    run_jump("j", 6'h02, 6'h00, S_JUMP, v_j);
    run_jump("jr", 6'h00, 6'h08, S_JR, v_jr);
    run_jump("jal", 6'h03, 6'h00, S_JAL, v_jal);

    // Unsupported opcode and unsupported R-type funct.
    opcode = 6'h3F; funct = 6'h00;
    cyc("ill_op.fetch", S_FETCH, v_fetch);
    cyc("ill_op.dec", S_DECODE, v_ill);
    opcode = 6'h00; funct = 6'h21;
    cyc("ill_fn.fetch", S_FETCH, v_fetch);
    cyc("ill_fn.dec", S_DECODE, v_ill);

    // Reset during a stalled MEM_WR drops mem_write at once.
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    cyc("swr.fetch", S_FETCH, v_fetch);
    cyc("swr.dec", S_DECODE, v_dec);
    cyc("swr.addr", S_MEM_ADDR, v_maddr);
    mem_ready = 1'b0;
    chk("swr.wr", S_MEM_WR, v_mwr);
    #1 rst_n = 1'b0;
    chk("swr.rst_now", S_FETCH, v_rst);
    @(negedge clk);
    mem_ready = 1'b1;
    cyc("swr.rst_hold", S_FETCH, v_rst);
    rst_n = 1'b1;
    run_jump("resume_j", 6'h02, 6'h00, S_JUMP, v_j);
    cyc("final.fetch", S_FETCH, v_fetch);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle MIPS datapath. Decodes the latched instruction's opcode/funct and sequences the datapath through fetch, decode, execute, memory and writeback states. Drives every datapath select and write enable, including the 2-bit `pc_src` that steers the four-input next-PC mux.

## Interface
Parameters:
- none (encodings below are fixed)

Ports (clock and reset first):
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC register load enable
- pc_src  out  2  next-PC select: 0 ALU result (PC+4), 1 ALUOut register (branch target), 2 A register (jr), 3 jump concat {PC[31:28],imm26,2'b00}
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  2  write address: 0 rt, 1 rd, 2 $31
- mem_to_reg  out  2  write data: 0 ALUOut, 1 MDR, 2 PC
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  0 B, 1 constant 4, 2 sign-ext imm, 3 sign-ext imm<<2
- alu_ctrl  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
- illegal  out  1  one-cycle pulse in DECODE for unsupported opcode/funct
- state  out  4  current state, debug only

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JR, JAL.
- Supported: R-type (opcode 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x08 jr), lw 0x23, sw 0x2B, addi 0x08, xori 0x0E, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- Outputs are Moore (decoded from state), except `pc_en` in BRANCH and strobes gated by `mem_ready`. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD, pc_src=0; ir_write=pc_en=mem_ready. Stay while mem_ready=0; leave for DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (precomputes branch target into ALUOut). Next state by opcode. R-type funct 0x08 → JR. Unsupported → FETCH with illegal=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready, then → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctrl from funct → R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, ADD (addi) or XOR (xori) → I_WB. I_WB: reg_write=1, reg_dst=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_en=zero (beq) or !zero (bne) → FETCH.
- JUMP: pc_src=3, pc_en=1 → FETCH. JR: pc_src=2, pc_en=1 → FETCH.
- JAL: pc_src=3, pc_en=1, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4) → FETCH.

## Timing
- Reset: rst_n low forces state=FETCH immediately. While low, pc_en, ir_write, mem_read, mem_write, reg_write and illegal are 0. Selects take their FETCH values.
- First FETCH cycle is the first rising edge after rst_n deasserts.
- Latency with mem_ready held at 1: lw 5 cycles; sw, R-type, addi, xori 4 cycles; beq, bne, j, jr, jal 3 cycles. Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write stay asserted, with a stable address select, until the cycle mem_ready=1. ir_write and pc_en in FETCH fire only in that cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction aborts it. No write enable may fire after rst_n falls.
- opcode/funct are sampled only in DECODE, R_EXEC, I_EXEC and BRANCH (IR is stable there).

## Test plan
- Reset, then mem_ready=1, opcode 0x00 funct 0x20 → state sequence FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 with reg_dst=1 only in R_WB; alu_ctrl=0 in R_EXEC.
- lw with mem_ready low for 2 cycles in MEM_RD → mem_read=1, i_or_d=1 held for 3 cycles; MEM_WB asserts reg_write, mem_to_reg=1; total 7 cycles.
- beq with zero=1, then zero=0 → pc_src=1 in BRANCH with pc_en=1, then pc_en=0. bne gives the inverse.
- j, jr (funct 0x08), jal → pc_src=3, 2, 3 respectively with pc_en=1 in the third cycle. jal also asserts reg_write, reg_dst=2, mem_to_reg=2.
- opcode 0x3F → illegal=1 for exactly one cycle in DECODE, then FETCH; no write enables asserted.
- rst_n pulled low during MEM_WR with mem_ready=0 → mem_write drops to 0 at once; state=FETCH; resumes fetching after release.
